// File: rtl/dma_burst_mem.sv
// Burst memory slave for the DMA read/write request channels.
// Serves len+1 word bursts from one word-addressed array, beat by beat.
module dma_burst_mem #(
  parameter int    ADDR_W    = 12,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_req_addr,
  input  logic [4:0]  rd_req_len,
  input  logic        rd_req_valid,
  output logic        rd_req_ready,
  output logic [31:0] rd_rdata,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        rd_last,
  input  logic [31:0] wr_req_addr,
  input  logic [4:0]  wr_req_len,
  input  logic        wr_req_valid,
  output logic        wr_req_ready,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        wr_last,
  output logic        busy,
  output logic        burst_err
);

  typedef enum logic [1:0] {IDLE, RD_LOAD, RD_BEAT, WR_BEAT} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [4:0]        len_q;
  logic [4:0]        cnt_q;
  logic              pri_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem_q [2**ADDR_W];

  logic [ADDR_W-1:0] idx_inc;
  logic              cnt_last;

  assign idx_inc  = idx_q + ADDR_W'(1);
  assign cnt_last = (cnt_q == len_q);

  // pri_q=1 means read was granted last and loses the next tie
  assign rd_req_ready = ~rst & (state_q == IDLE) & rd_req_valid & (~wr_req_valid | ~pri_q);
  assign wr_req_ready = ~rst & (state_q == IDLE) & wr_req_valid & (~rd_req_valid | pri_q);

  assign rd_valid  = (state_q == RD_BEAT);
  assign rd_last   = (state_q == RD_BEAT) & cnt_last;
  assign wr_ready  = (state_q == WR_BEAT);
  assign busy      = (state_q != IDLE);
  assign rd_rdata  = rdata_q;
  assign burst_err = err_q;

  always_ff @(posedge clk) begin
    if ((state_q == WR_BEAT) && wr_valid) begin
      mem_q[idx_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      pri_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_req_ready) begin
            idx_q   <= rd_req_addr[ADDR_W+1:2];
            len_q   <= rd_req_len;
            cnt_q   <= '0;
            pri_q   <= 1'b1;
            state_q <= RD_LOAD;
          end else if (wr_req_ready) begin
            idx_q   <= wr_req_addr[ADDR_W+1:2];
            len_q   <= wr_req_len;
            cnt_q   <= '0;
            pri_q   <= 1'b0;
            state_q <= WR_BEAT;
          end
        end
        RD_LOAD: begin
          rdata_q <= mem_q[idx_q];
          state_q <= RD_BEAT;
        end
        RD_BEAT: begin
          if (rd_ready) begin
            if (cnt_last) begin
              state_q <= IDLE;
            end else begin
              // prefetch the next word on the same edge so beats run back-to-back
              idx_q   <= idx_inc;
              cnt_q   <= cnt_q + 5'd1;
              rdata_q <= mem_q[idx_inc];
            end
          end
        end
        WR_BEAT: begin
          if (wr_valid) begin
            idx_q <= idx_inc;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_last) begin
              state_q <= IDLE;
              if (!wr_last) err_q <= 1'b1;
            end else if (wr_last) begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_burst_mem.sv
// Self-checking bench for dma_burst_mem: directed plus random bursts
// compared against an array-based memory and arbitration model.
module tb_dma_burst_mem;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_req_addr, wr_req_addr, rd_rdata, wr_data;
  logic [4:0]  rd_req_len, wr_req_len;
  logic        rd_req_valid, rd_req_ready, rd_valid, rd_ready, rd_last;
  logic        wr_req_valid, wr_req_ready, wr_valid, wr_ready, wr_last;
  logic        busy, burst_err;

  bit [31:0] mdl_mem [DEPTH];
  bit        mdl_pri;
  bit        mdl_err;
  int        checks = 0;
  int        errors = 0;

  always #5 clk = ~clk;

  dma_burst_mem #(.ADDR_W(AW), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len), .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready), .rd_rdata(rd_rdata), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last),
    .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len), .wr_req_valid(wr_req_valid),
    .wr_req_ready(wr_req_ready), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_last(wr_last),
    .busy(busy), .burst_err(burst_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request cycle (possibly both channels), then service whichever was granted.
  // stall: 0 = engine always ready / no gaps, 1 = rd_ready 1,0,0 pattern, 2 = random.
  // dmode 1 writes base+beat, otherwise random data. abort_at >= 0 resets mid-read.
  task automatic burst(input bit rv, input bit wv,
                       input logic [31:0] raddr, input logic [4:0] rlen,
                       input logic [31:0] waddr, input logic [4:0] wlen,
                       input int lastpos, input int stall, input int dmode,
                       input logic [31:0] base, input int abort_at);
    bit g_rd, g_wr;
    int idx, len, beats, cyc;
    rd_req_valid = rv; wr_req_valid = wv;
    rd_req_addr = raddr; rd_req_len = rlen;
    wr_req_addr = waddr; wr_req_len = wlen;
    #1;
    g_rd = rv && (!wv || !mdl_pri);
    g_wr = wv && (!rv || mdl_pri);
    chk("rd_req_ready", rd_req_ready, g_rd);
    chk("wr_req_ready", wr_req_ready, g_wr);
    tick();
    rd_req_valid = 0; wr_req_valid = 0;
    if (!g_rd && !g_wr) return;
    mdl_pri = g_rd;
    chk("busy_after_grant", busy, 1);
    beats = 0; cyc = 0;
    if (g_rd) begin
      idx = int'(raddr[AW+1:2]); len = int'(rlen);
      chk("rd_valid_load_cycle", rd_valid, 0);
      tick();
      while (beats <= len && cyc < 400) begin
        if (beats == abort_at) begin
          rst = 1; #1;
          chk("abort_rd_valid", rd_valid, 0);
          chk("abort_rd_last", rd_last, 0);
          chk("abort_rd_rdata", rd_rdata, 0);
          chk("abort_busy", busy, 0);
          mdl_pri = 0; mdl_err = 0; rd_ready = 0;
          tick(); rst = 0; tick();
          chk("abort_idle_after_release", busy, 0);
          chk("abort_burst_err", burst_err, 0);
          return;
        end
        case (stall)
          0: rd_ready = 1;
          1: rd_ready = (cyc % 3 == 0);
          default: rd_ready = 1'($urandom_range(0, 1));
        endcase
        chk("rd_valid", rd_valid, 1);
        chk("rd_rdata", rd_rdata, mdl_mem[(idx + beats) % DEPTH]);
        chk("rd_last", rd_last, (beats == len));
        if (rd_ready) beats++;
        cyc++;
        tick();
      end
      rd_ready = 0;
      chk("rd_handshakes", beats, len + 1);
      chk("rd_valid_after", rd_valid, 0);
      chk("busy_after_rd", busy, 0);
    end else begin
      idx = int'(waddr[AW+1:2]); len = int'(wlen);
      while (beats <= len && cyc < 400) begin
        wr_valid = (stall == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        wr_data  = (dmode == 1) ? base + beats : $urandom;
        wr_last  = wr_valid && (beats == lastpos);
        chk("wr_ready", wr_ready, 1);
        if (wr_valid) begin
          mdl_mem[(idx + beats) % DEPTH] = wr_data;
          if (wr_last != (beats == len)) mdl_err = 1;
          beats++;
        end
        cyc++;
        tick();
      end
      wr_valid = 0; wr_last = 0;
      chk("wr_beats", beats, len + 1);
      chk("wr_ready_after", wr_ready, 0);
      chk("busy_after_wr", busy, 0);
      chk("burst_err", burst_err, mdl_err);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [4:0] l, input int stall);
    burst(1, 0, a, l, 0, 0, 0, stall, 0, 0, -1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [4:0] l, input int lastpos,
                    input int stall, input int dmode, input logic [31:0] base);
    burst(0, 1, 0, 0, a, l, lastpos, stall, dmode, base, -1);
  endtask

  initial begin
    rst = 1;
    rd_req_valid = 1; wr_req_valid = 1;
    rd_req_addr = 0; rd_req_len = 0; wr_req_addr = 0; wr_req_len = 0;
    rd_ready = 0; wr_data = 0; wr_valid = 0; wr_last = 0;
    mdl_pri = 0; mdl_err = 0;
    #12;
    chk("rst_rd_req_ready", rd_req_ready, 0);
    chk("rst_wr_req_ready", wr_req_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_rdata", rd_rdata, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_burst_err", burst_err, 0);
    rd_req_valid = 0; wr_req_valid = 0;
    tick(); rst = 0; tick();

    // fill the whole array; high and low address bits are don't-care
    for (int k = 0; k < DEPTH / 32; k++) begin
      wr(($urandom & ~32'h3FF) | (k * 128) | $urandom_range(0, 3), 5'd31, 31, 2, 0, 0);
    end

    wr(32'h100, 5'd7, 7, 0, 1, 32'hA0);
    rd(32'h100, 5'd7, 0);
    rd(32'h100, 5'd7, 1);
    wr(32'h200, 5'd7, 7, 0, 1, 32'h10);
    rd(32'h200, 5'd7, 0);

    // framing error: wr_last on beat 2 of 4, then a clean burst keeps it sticky
    wr(32'h300, 5'd3, 1, 0, 1, 32'h55);
    rd(32'h300, 5'd3, 0);
    wr(32'h140, 5'd2, 2, 2, 0, 0);
    chk("err_sticky", burst_err, 1);

    rst = 1; #1;
    chk("err_cleared_by_rst", burst_err, 0);
    mdl_err = 0; mdl_pri = 0;
    tick(); rst = 0; tick();

    burst(1, 1, 32'h080, 5'd4, 32'h0C0, 5'd5, 5, 0, 0, 0, -1);
    burst(1, 1, 32'h080, 5'd4, 32'h0C0, 5'd5, 5, 0, 0, 0, -1);
    burst(1, 1, 32'h0C0, 5'd5, 32'h080, 5'd4, 4, 0, 0, 0, -1);

    rd(32'hABCD_E3FC, 5'd3, 0);
    wr(32'h0000_03F8, 5'd4, 4, 0, 1, 32'h77);
    rd(32'h0000_03F8, 5'd4, 2);

    for (int n = 0; n < 24; n++) begin
      bit rv, wv;
      logic [4:0] rl, wl;
      rv = 1'($urandom_range(0, 1));
      wv = 1'($urandom_range(0, 1));
      if (!rv && !wv) rv = 1;
      rl = 5'($urandom_range(0, 31));
      wl = 5'($urandom_range(0, 31));
      burst(rv, wv, $urandom, rl, $urandom, wl,
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'(wl),
            int'($urandom_range(0, 2)), 0, 0, -1);
    end

    burst(1, 0, 32'h100, 5'd7, 0, 0, 0, 0, 0, 0, 3);
    rd(32'h100, 5'd7, 0);
    rd(32'h200, 5'd7, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
